// File: rtl/tilt_cmd_ctrl_if.sv
// tilt_cmd_if: bundle of the tilt command generator's control/sample inputs and
// command/status outputs. Clock and reset stay outside the bundle.
//   master : drives ctrlClk/en/manual/samples, observes Rx/Ry/cmdValid/mode/slewing/sat
//   slave  : the tilt_cmd_ctrl side
interface tilt_cmd_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 13
);
  logic                    ctrlClk;
  logic                    en;
  logic                    manual;
  logic [IN_W-1:0]         x_joy;
  logic [IN_W-1:0]         y_joy;
  logic [IN_W-1:0]         x_fb;
  logic [IN_W-1:0]         y_fb;
  logic signed [OUT_W-1:0] Rx;
  logic signed [OUT_W-1:0] Ry;
  logic                    cmdValid;
  logic [1:0]              mode;
  logic                    slewing;
  logic [1:0]              sat;

  modport master (
    output ctrlClk, en, manual, x_joy, y_joy, x_fb, y_fb,
    input  Rx, Ry, cmdValid, mode, slewing, sat
  );

  modport slave (
    input  ctrlClk, en, manual, x_joy, y_joy, x_fb, y_fb,
    output Rx, Ry, cmdValid, mode, slewing, sat
  );
endinterface

// File: rtl/tilt_cmd_ctrl.sv
// tilt_cmd_ctrl: two-axis plate tilt command generator. Picks joystick or
// feedback samples, maps them to signed tilt, saturates to +/-LIMIT and
// slew-limits the Rx/Ry commands by SLEW per control tick. A mode FSM handles
// enable, parking the plate level and bumpless source switching.
// Ports:
//   sysClk    system clock, everything on posedge
//   sysRst_n  synchronous active-low reset
//   bus       tilt_cmd_if.slave: ctrlClk strobe, en, manual, x/y joy+fb samples
//             in; Rx, Ry, cmdValid, mode, slewing, sat out
// Pipeline: stage 1 on a strobe edge computes clamped targets and steps the
// FSM; stage 2 on the following edge applies the slew-limited update.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | plate inactive, no updates issued
// MANUAL   | tracking joystick samples
// FEEDBACK | tracking feedback samples
// PARK     | ramping both axes to 0, returns to IDLE once level
module tilt_cmd_ctrl #(
  parameter int IN_W   = 12,
  parameter int OUT_W  = 13,
  parameter int GAIN   = 682,
  parameter int GAIN_W = 11,
  parameter int LIMIT  = 300,
  parameter int SLEW   = 32
) (
  input  logic       sysClk,
  input  logic       sysRst_n,
  tilt_cmd_if.slave  bus
);

  localparam int PROD_W = IN_W + GAIN_W;
  localparam int T_W    = OUT_W + 1;

  localparam logic signed [T_W-1:0] HALF   = T_W'(GAIN >> 1);
  localparam logic signed [T_W-1:0] LIM_P  = T_W'(LIMIT);
  localparam logic signed [T_W-1:0] LIM_N  = T_W'(-LIMIT);
  localparam logic signed [T_W-1:0] SLEW_P = T_W'(SLEW);
  localparam logic signed [T_W-1:0] SLEW_N = T_W'(-SLEW);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MANUAL   = 2'd1,
    FEEDBACK = 2'd2,
    PARK     = 2'd3
  } mode_t;

  mode_t state_q, state_d;

  logic signed [T_W-1:0]   tgt_x_q, tgt_y_q;
  logic signed [T_W-1:0]   tgt_x_d, tgt_y_d;
  logic [1:0]              sat_q, sat_d;
  logic                    s2_vld_q;
  logic                    s1_fire;

  logic signed [OUT_W-1:0] rx_q, ry_q;
  logic signed [OUT_W-1:0] rx_nxt, ry_nxt;
  logic                    valid_q;
  logic                    slewing_q;
  logic                    clip_x, clip_y;
  logic                    park_done;

  logic [IN_W-1:0]         src_x, src_y;
  logic signed [T_W-1:0]   map_a, map_b;
  logic signed [T_W-1:0]   raw_x, raw_y;
  logic signed [T_W-1:0]   dx, dy;

  // Unsigned product, shift back to the gain range, then re-centre around 0.
  function automatic logic signed [T_W-1:0] map_s(input logic [IN_W-1:0] s);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(s) * PROD_W'(GAIN);
    return $signed(T_W'(prod >> IN_W)) - HALF;
  endfunction

  function automatic logic signed [T_W-1:0] lim(input logic signed [T_W-1:0] v);
    if (v > LIM_P) return LIM_P;
    if (v < LIM_N) return LIM_N;
    return v;
  endfunction

  // Stage 2 arithmetic: step toward target by at most SLEW.
  always_comb begin
    dx     = tgt_x_q - T_W'(rx_q);
    dy     = tgt_y_q - T_W'(ry_q);
    clip_x = 1'b0;
    clip_y = 1'b0;
    if (SLEW > 0) begin
      if (dx > SLEW_P) begin
        dx     = SLEW_P;
        clip_x = 1'b1;
      end else if (dx < SLEW_N) begin
        dx     = SLEW_N;
        clip_x = 1'b1;
      end
      if (dy > SLEW_P) begin
        dy     = SLEW_P;
        clip_y = 1'b1;
      end else if (dy < SLEW_N) begin
        dy     = SLEW_N;
        clip_y = 1'b1;
      end
    end
    rx_nxt = OUT_W'(T_W'(rx_q) + dx);
    ry_nxt = OUT_W'(T_W'(ry_q) + dy);
  end

  // With back-to-back strobes the previous update lands on the same edge, so
  // judge "level" on the value the plate is about to hold.
  always_comb begin
    if (s2_vld_q) park_done = (rx_nxt == '0) && (ry_nxt == '0);
    else          park_done = (rx_q == '0) && (ry_q == '0);
  end

  always_ff @(posedge sysClk) begin
    if (!sysRst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.ctrlClk) begin
      case (state_q)
        IDLE: begin
          if (bus.en) state_d = bus.manual ? MANUAL : FEEDBACK;
        end
        MANUAL, FEEDBACK: begin
          if (!bus.en) state_d = PARK;
          else         state_d = bus.manual ? MANUAL : FEEDBACK;
        end
        PARK: begin
          if (bus.en)         state_d = bus.manual ? MANUAL : FEEDBACK;
          else if (park_done) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage 1: targets follow the state being entered, so the strobe that
  // leaves IDLE already produces a tracking update.
  always_comb begin
    src_x = bus.x_fb;
    src_y = bus.y_fb;
    if (state_d == MANUAL) begin
      src_x = bus.x_joy;
      src_y = bus.y_joy;
    end
    map_a = map_s(src_x);
    map_b = map_s(src_y);
    raw_x = '0;
    raw_y = '0;
    if ((state_d == MANUAL) || (state_d == FEEDBACK)) begin
      raw_y = map_a;
      raw_x = -map_b;
    end
    tgt_x_d = lim(raw_x);
    tgt_y_d = lim(raw_y);
    sat_d   = {(raw_x > LIM_P) || (raw_x < LIM_N),
               (raw_y > LIM_P) || (raw_y < LIM_N)};
    s1_fire = bus.ctrlClk && (state_d != IDLE);
  end

  always_ff @(posedge sysClk) begin
    if (!sysRst_n) begin
      tgt_x_q  <= '0;
      tgt_y_q  <= '0;
      sat_q    <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_fire;
      if (s1_fire) begin
        tgt_x_q <= tgt_x_d;
        tgt_y_q <= tgt_y_d;
        sat_q   <= sat_d;
      end
    end
  end

  always_ff @(posedge sysClk) begin
    if (!sysRst_n) begin
      rx_q      <= '0;
      ry_q      <= '0;
      valid_q   <= 1'b0;
      slewing_q <= 1'b0;
    end else begin
      valid_q <= s2_vld_q;
      if (s2_vld_q) begin
        rx_q      <= rx_nxt;
        ry_q      <= ry_nxt;
        slewing_q <= clip_x || clip_y;
      end
    end
  end

  assign bus.Rx       = rx_q;
  assign bus.Ry       = ry_q;
  assign bus.cmdValid = valid_q;
  assign bus.mode     = state_q;
  assign bus.slewing  = slewing_q;
  assign bus.sat      = sat_q;

endmodule
